// File: rtl/spi_target.sv
// SPI mode 3 target (CPOL=1, CPHA=1, MSB first), fully synchronous to clk_in.
// Receives SIZE bits into r_data_out and shifts out a response word loaded at CS fall.
module spi_target #(
  parameter int SIZE        = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            sclk_in,
  input  logic            cs_n_in,
  input  logic            mosi_in,
  output logic            miso_out,
  output logic            miso_oe_out,
  input  logic [SIZE-1:0] data_in,
  output logic [SIZE-1:0] r_data_out,
  output logic            r_valid_out,
  output logic            r_busy_out,
  output logic            r_frame_error_out
);

  localparam int CNT_W = $clog2(SIZE + 1);
  localparam int REL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {RELEASE, IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_n_sync, mosi_sync;
  logic                   sclk_d, cs_n_d;
  logic [CNT_W-1:0]       bit_cnt;
  logic [REL_W-1:0]       rel_cnt;
  logic [SIZE-1:0]        tx;
  // The newest bit comes straight from the synchronizer, so only SIZE-1 bits are stored.
  logic [SIZE-2:0]        rx;
  logic [SIZE-1:0]        rx_next;

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, last_rise;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sclk_sync <= '1;
      cs_n_sync <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      cs_n_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_n_d    <= cs_n_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_n_s & cs_n_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;
  assign last_rise = sclk_rise && (bit_cnt == CNT_W'(SIZE - 1));
  assign rx_next   = {rx, mosi_s};

  assign miso_out  = (state == SHIFT) ? tx[SIZE-1] : 1'b1;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      // NOTE: shift registers are reset too, so nothing stale can leak onto MISO or r_data_out.
      state             <= RELEASE;
      rel_cnt           <= '0;
      bit_cnt           <= '0;
      tx                <= '0;
      rx                <= '0;
      r_data_out        <= '0;
      r_valid_out       <= 1'b0;
      r_frame_error_out <= 1'b0;
      r_busy_out        <= 1'b0;
      miso_oe_out       <= 1'b0;
    end else begin
      r_valid_out       <= 1'b0;
      r_frame_error_out <= 1'b0;
      case (state)
        // Wait for the cs_n chain to refill from the pin, so its reset value of 1 is not
        // taken for a released CS while the initiator is still mid-frame.
        RELEASE: begin
          if (rel_cnt != REL_W'(SYNC_STAGES)) begin
            rel_cnt <= rel_cnt + REL_W'(1);
          end else if (cs_n_s) begin
            rel_cnt <= '0;
            state   <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            tx          <= data_in;
            rx          <= '0;
            bit_cnt     <= '0;
            r_busy_out  <= 1'b1;
            miso_oe_out <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx      <= rx_next[SIZE-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (sclk_fall && bit_cnt != '0) tx <= {tx[SIZE-2:0], 1'b0};
          // A final rising edge beats a simultaneous CS rise: the frame counts as complete.
          if (last_rise) begin
            r_data_out  <= rx_next;
            r_valid_out <= 1'b1;
            if (cs_rise) begin
              r_busy_out  <= 1'b0;
              miso_oe_out <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= DONE;
            end
          end else if (cs_rise) begin
            r_frame_error_out <= 1'b1;
            r_busy_out        <= 1'b0;
            miso_oe_out       <= 1'b0;
            state             <= IDLE;
          end
        end
        DONE: begin
          if (cs_rise) begin
            r_busy_out  <= 1'b0;
            miso_oe_out <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= RELEASE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target (SIZE=8): a driver acts as the SPI initiator and queues
// the expected frame outcome; a monitor checks every valid / error pulse against the queue.
module tb_spi_target;

  localparam int SIZE = 8;
  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic            clk_in   = 1'b0;
  logic            reset_in = 1'b1;
  logic            sclk_in  = 1'b1;
  logic            cs_n_in  = 1'b1;
  logic            mosi_in  = 1'b0;
  logic [SIZE-1:0] data_in  = '0;
  logic            miso_out, miso_oe_out;
  logic [SIZE-1:0] r_data_out;
  logic            r_valid_out, r_busy_out, r_frame_error_out;

  spi_target #(.SIZE(SIZE), .SYNC_STAGES(SYNC)) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .sclk_in           (sclk_in),
    .cs_n_in           (cs_n_in),
    .mosi_in           (mosi_in),
    .miso_out          (miso_out),
    .miso_oe_out       (miso_oe_out),
    .data_in           (data_in),
    .r_data_out        (r_data_out),
    .r_valid_out       (r_valid_out),
    .r_busy_out        (r_busy_out),
    .r_frame_error_out (r_frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit              is_err;
    logic [SIZE-1:0] data;
  } ev_t;

  ev_t             exp_q[$];
  ev_t             mon_e;
  logic [SIZE-1:0] model_data = '0;
  int              n_cmp  = 0;
  int              n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, r_busy_out, 1'b0);
    check({tag, "_oe"}, miso_oe_out, 1'b0);
    check({tag, "_miso"}, miso_out, 1'b1);
  endtask

  // Initiator: sends nbits of mosi_word MSB first; resp is the word the target should
  // return. At bit index chg the driver changes data_in to zero mid-frame.
  task automatic do_frame(input logic [15:0] mosi_word, input int nbits,
                          input logic [SIZE-1:0] resp, input int chg);
    ev_t e;
    if (nbits >= SIZE) begin
      model_data = mosi_word[nbits-1 -: SIZE];
      e.is_err   = 1'b0;
    end else begin
      e.is_err   = 1'b1;
    end
    e.data = model_data;
    exp_q.push_back(e);

    data_in = resp;
    cs_n_in = 1'b0;
    tick(HALF + 1);
    check("sel_busy", r_busy_out, 1'b1);
    check("sel_oe", miso_oe_out, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      sclk_in = 1'b0;
      mosi_in = mosi_word[nbits-1-i];
      if (i == chg) data_in = '0;
      tick(HALF);
      sclk_in = 1'b1;
      check("miso_bit", miso_out, (i < SIZE) ? resp[SIZE-1-i] : 1'b1);
      tick(HALF);
    end
    cs_n_in = 1'b1;
    tick(HALF);
    check_idle("post_frame");
  endtask

  always @(negedge clk_in) begin
    if (r_valid_out || r_frame_error_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'b0, r_valid_out, r_frame_error_out}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {30'b0, r_valid_out, r_frame_error_out},
              mon_e.is_err ? 32'h1 : 32'h2);
        check("r_data_out", r_data_out, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SIZE-1:0] r_resp;
    logic [15:0]     r_word;
    int              r_nb;

    tick(3);
    check("rst_data", r_data_out, '0);
    check("rst_valid", r_valid_out, 1'b0);
    check("rst_err", r_frame_error_out, 1'b0);
    check_idle("rst");
    reset_in = 1'b0;
    tick(6);

    do_frame(16'h003C, 8, 8'hA5, -1);
    do_frame(16'h0001, 8, 8'h81, -1);
    do_frame(16'h00FE, 8, 8'h7E, -1);
    do_frame(16'h0015, 5, 8'hFF, -1);
    do_frame(16'h0055, 8, 8'h33, -1);
    do_frame(16'h0C3F, 12, 8'h96, -1);
    do_frame(16'h006B, 8, 8'hA5, 3);

    // Reset one cycle after the third bit while CS stays low.
    data_in = 8'h3C;
    cs_n_in = 1'b0;
    tick(HALF + 1);
    for (int i = 0; i < 3; i++) begin
      sclk_in = 1'b0;
      mosi_in = 1'b1;
      tick(HALF);
      sclk_in = 1'b1;
      tick(1);
    end
    reset_in = 1'b1;
    tick(1);
    reset_in = 1'b0;
    model_data = '0;
    tick(10);
    check("midrst_data", r_data_out, '0);
    check_idle("midrst");
    cs_n_in = 1'b1;
    tick(8);
    do_frame(16'h009A, 8, 8'h5C, -1);

    for (int k = 0; k < 8; k++) begin
      r_resp = SIZE'($urandom);
      r_word = 16'($urandom);
      r_nb   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 12)) : SIZE;
      do_frame(r_word, r_nb, r_resp, int'($urandom_range(1, 7)));
    end

    tick(10);
    check("pending_events", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
